axi_io_line_responder: RTL and testbench

- Responder end of the cache line-transfer interface: the axi_io valid/ready, 512-bit line channel that the cache side drives.
- Accepts one line request at a time and breaks it into 64-bit beats on a simple req/ack memory port.
- For reads, assembles the beats into a 512-bit line and returns it with a one-cycle ready pulse.
- Sits between the cache subsystem and the memory or AXI4 master port. Also serves as the simulation memory responder.

---
 rtl/axi_io_line_responder_pkg.sv | 36 +++
 rtl/axi_io_beat_strobe.sv | 16 +
 rtl/axi_io_line_responder.sv | 143 ++++++++++++++
 tb/tb_axi_io_line_responder.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_io_line_responder_pkg.sv
// Shared constants and types for the axi_io line responder and its strobe helper.
package axi_io_line_responder_pkg;

  localparam int LINE_WIDTH = 512;
  localparam int BEAT_WIDTH = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_DRAIN
  } state_t;

  typedef enum logic [1:0] {
    SIZE_1B = 2'd0,
    SIZE_2B = 2'd1,
    SIZE_4B = 2'd2,
    SIZE_8B = 2'd3
  } size_t;

  // Unshifted byte-enable mask covering 2^size bytes.
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    logic [7:0] mask;
    mask = 8'h00;
    case (size)
      SIZE_1B: mask = 8'h01;
      SIZE_2B: mask = 8'h03;
      SIZE_4B: mask = 8'h0F;
      SIZE_8B: mask = 8'hFF;
      default: mask = 8'h00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/axi_io_beat_strobe.sv
// Byte strobes for one 64-bit beat from an access size and the low address bits.
module axi_io_beat_strobe
  import axi_io_line_responder_pkg::*;
(
  input  logic [1:0] size,
  input  logic [2:0] offset,
  output logic [7:0] wstrb
);

  logic [7:0] base_mask;

  assign base_mask = size_mask(size);
  // The 8-bit shift drops any lanes pushed past the top byte.
  assign wstrb     = base_mask << offset;

endmodule

// File: rtl/axi_io_line_responder.sv
// Responder for 512-bit axi_io line requests: splits each line into 64-bit memory
// beats on a req/ack port and reassembles read beats into the returned line.
module axi_io_line_responder
  import axi_io_line_responder_pkg::*;
#(
  parameter int BEAT_W    = BEAT_WIDTH,
  parameter int MAX_BEATS = LINE_WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_axi_io_valid,
  input  logic                  i_axi_io_op,
  input  logic [63:0]           i_axi_io_addr,
  input  logic [LINE_WIDTH-1:0] i_axi_io_wdata,
  input  logic [1:0]            i_axi_io_size,
  input  logic [7:0]            i_axi_io_blks,
  output logic                  o_axi_io_ready,
  output logic [LINE_WIDTH-1:0] o_axi_io_rdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [63:0]           o_mem_addr,
  output logic [BEAT_W-1:0]     o_mem_wdata,
  output logic [BEAT_W/8-1:0]   o_mem_wstrb,
  input  logic                  i_mem_ack,
  input  logic [BEAT_W-1:0]     i_mem_rdata
);

  localparam int CNT_W = $clog2(MAX_BEATS);
  localparam int OFF_W = $clog2(BEAT_W / 8);

  state_t                  state_reg;
  logic                    op_reg;
  logic [63:0]             addr_reg;
  logic [LINE_WIDTH-1:0]   wdata_reg;
  logic [1:0]              size_reg;
  logic [CNT_W-1:0]        last_reg;
  logic [CNT_W-1:0]        beat_reg;
  logic [LINE_WIDTH-1:0]   rdata_reg;
  logic                    ready_reg;
  logic                    req_reg;
  logic                    we_reg;
  logic [63:0]             maddr_reg;
  logic [BEAT_W-1:0]       mwdata_reg;
  logic [BEAT_W/8-1:0]     wstrb_reg;

  logic [CNT_W-1:0]        last_next;
  logic [63:0]             beat_addr;
  logic [BEAT_W-1:0]       beat_wdata;
  logic [7:0]              single_strb;

  // Oversized blks requests are clamped to a full line.
  assign last_next = (i_axi_io_blks > 8'(MAX_BEATS - 1)) ? CNT_W'(MAX_BEATS - 1)
                                                          : i_axi_io_blks[CNT_W-1:0];

  // Beat 0 keeps the caller's byte offset; later beats start on aligned words.
  assign beat_addr  = (beat_reg == '0) ? addr_reg
                    : {addr_reg[63:OFF_W], OFF_W'(0)} + (64'(beat_reg) * 64'(BEAT_W / 8));
  assign beat_wdata = wdata_reg[beat_reg*BEAT_W +: BEAT_W];

  axi_io_beat_strobe u_strobe (
    .size   (size_reg),
    .offset (addr_reg[2:0]),
    .wstrb  (single_strb)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= ST_IDLE;
      op_reg     <= 1'b0;
      addr_reg   <= '0;
      wdata_reg  <= '0;
      size_reg   <= '0;
      last_reg   <= '0;
      beat_reg   <= '0;
      rdata_reg  <= '0;
      ready_reg  <= 1'b0;
      req_reg    <= 1'b0;
      we_reg     <= 1'b0;
      maddr_reg  <= '0;
      mwdata_reg <= '0;
      wstrb_reg  <= '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          ready_reg <= 1'b0;
          if (i_axi_io_valid) begin
            op_reg    <= i_axi_io_op;
            addr_reg  <= i_axi_io_addr;
            wdata_reg <= i_axi_io_wdata;
            size_reg  <= i_axi_io_size;
            last_reg  <= last_next;
            beat_reg  <= '0;
            rdata_reg <= '0;
            state_reg <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          req_reg    <= 1'b1;
          we_reg     <= op_reg;
          maddr_reg  <= beat_addr;
          mwdata_reg <= beat_wdata;
          wstrb_reg  <= (last_reg == '0) ? single_strb : '1;
          state_reg  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (i_mem_ack) begin
            req_reg <= 1'b0;
            if (!op_reg) begin
              rdata_reg[beat_reg*BEAT_W +: BEAT_W] <= i_mem_rdata;
            end
            if (beat_reg == last_reg) begin
              state_reg <= ST_DONE;
            end else begin
              beat_reg  <= beat_reg + 1'b1;
              state_reg <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          ready_reg <= 1'b1;
          state_reg <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // A valid still held from the finished request must not restart it.
          ready_reg <= 1'b0;
          if (!i_axi_io_valid) begin
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_axi_io_ready = ready_reg;
  assign o_axi_io_rdata = rdata_reg;
  assign o_mem_req      = req_reg;
  assign o_mem_we       = we_reg;
  assign o_mem_addr     = maddr_reg;
  assign o_mem_wdata    = mwdata_reg;
  assign o_mem_wstrb    = wstrb_reg;

endmodule

// File: tb/tb_axi_io_line_responder.sv
// Directed bench for axi_io_line_responder with a latency-programmable memory model.
module tb_axi_io_line_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid = 1'b0;
  logic         op = 1'b0;
  logic [63:0]  addr = '0;
  logic [511:0] wdata = '0;
  logic [1:0]   size = '0;
  logic [7:0]   blks = '0;
  logic         ready;
  logic [511:0] rdata;
  logic         mem_req, mem_we;
  logic [63:0]  mem_addr, mem_wdata, mem_rdata;
  logic [7:0]   mem_wstrb;
  logic         mem_ack;

  int tests = 0;
  int fails = 0;

  // Memory model state.
  int  wait_cnt = 0;
  int  lat_cur = 0;
  int  lat_fixed = 1;
  bit  rand_mode = 1'b0;
  bit  stray = 1'b0;
  int  log_n = 0;
  int  ready_cnt = 0;
  logic [63:0] log_addr  [0:255];
  logic [63:0] log_wdata [0:255];
  logic [7:0]  log_wstrb [0:255];
  logic        log_we    [0:255];

  always #5 clk = ~clk;

  axi_io_line_responder dut (
    .clk            (clk),
    .rst            (rst),
    .i_axi_io_valid (valid),
    .i_axi_io_op    (op),
    .i_axi_io_addr  (addr),
    .i_axi_io_wdata (wdata),
    .i_axi_io_size  (size),
    .i_axi_io_blks  (blks),
    .o_axi_io_ready (ready),
    .o_axi_io_rdata (rdata),
    .o_mem_req      (mem_req),
    .o_mem_we       (mem_we),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_wstrb    (mem_wstrb),
    .i_mem_ack      (mem_ack),
    .i_mem_rdata    (mem_rdata)
  );

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    return {~a[31:0], a[31:0]};
  endfunction

  assign mem_ack   = (mem_req && (wait_cnt == (rand_mode ? lat_cur : lat_fixed))) || stray;
  assign mem_rdata = mem_data(mem_addr);

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 0;
      lat_cur  <= 0;
    end else if (mem_ack && mem_req) begin
      log_addr[log_n]  <= mem_addr;
      log_wdata[log_n] <= mem_wdata;
      log_wstrb[log_n] <= mem_wstrb;
      log_we[log_n]    <= mem_we;
      log_n    <= log_n + 1;
      wait_cnt <= 0;
      lat_cur  <= int'($urandom_range(5, 0));
    end else if (mem_req) begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  always @(negedge clk) if (ready) ready_cnt++;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic outputs_zero(input string tag);
    check({tag, "_ready"}, 512'(ready), 512'(0));
    check({tag, "_rdata"}, rdata, 512'(0));
    check({tag, "_req"}, 512'(mem_req), 512'(0));
    check({tag, "_we"}, 512'(mem_we), 512'(0));
    check({tag, "_addr"}, 512'(mem_addr), 512'(0));
    check({tag, "_wdata"}, 512'(mem_wdata), 512'(0));
    check({tag, "_wstrb"}, 512'(mem_wstrb), 512'(0));
  endtask

  // One request: raise valid, wait for ready, hold valid `hold` cycles, drop it.
  task automatic do_req(input logic o, input logic [63:0] a, input logic [511:0] wd,
                        input logic [1:0] sz, input logic [7:0] bk, input int hold,
                        input bit chk_stable, output int cyc, output logic [511:0] rd);
    int   rc0;
    bit   seen;
    bit   stall;
    logic [63:0] pa, pw;
    logic [7:0]  ps;
    rc0 = ready_cnt; cyc = 0; seen = 0; stall = 0; rd = '0;
    pa = '0; pw = '0; ps = '0;
    @(negedge clk);
    valid = 1'b1; op = o; addr = a; wdata = wd; size = sz; blks = bk;
    while (!seen && cyc < 1000) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 2) begin
        addr = ~a; wdata = ~wd; size = ~sz; op = ~o;
      end
      if (chk_stable && stall) begin
        check("stall_req", 512'(mem_req), 512'(1));
        check("stall_addr", 512'(mem_addr), 512'(pa));
        check("stall_wdata", 512'(mem_wdata), 512'(pw));
        check("stall_wstrb", 512'(mem_wstrb), 512'(ps));
      end
      stall = mem_req && !mem_ack;
      pa = mem_addr; pw = mem_wdata; ps = mem_wstrb;
      if (ready) begin
        seen = 1'b1;
        rd = rdata;
      end
    end
    check("ready_seen", 512'(seen), 512'(1));
    repeat (hold) @(negedge clk);
    valid = 1'b0;
    repeat (3) @(negedge clk);
    check("one_ready_pulse", 512'(ready_cnt - rc0), 512'(1));
  endtask

  initial begin
    int cyc;
    int base;
    logic [511:0] rd;
    logic [511:0] line;
    logic [63:0]  a0;

    // Reset state.
    repeat (3) @(negedge clk);
    outputs_zero("in_reset");
    rst = 1'b1;
    @(negedge clk);
    outputs_zero("after_reset");

    // 8-beat read, 1-cycle memory: 26 cycles, addr-based data.
    base = log_n; lat_fixed = 1; rand_mode = 0;
    a0 = 64'h0000_0000_8000_0040;
    do_req(1'b0, a0, '0, 2'd3, 8'd7, 0, 1'b0, cyc, rd);
    check("rd8_latency", 512'(cyc), 512'(26));
    check("rd8_beats", 512'(log_n - base), 512'(8));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("rd8_addr%0d", i), 512'(log_addr[base+i]), 512'(a0 + 64'(8*i)));
      check($sformatf("rd8_data%0d", i), 512'(rd[64*i +: 64]), 512'(mem_data(a0 + 64'(8*i))));
    end
    check("rd8_we", 512'(log_we[base]), 512'(0));
    check("rd8_wstrb", 512'(log_wstrb[base+3]), 512'(8'hFF));

    // 8-beat write with incrementing bytes.
    for (int k = 0; k < 64; k++) line[8*k +: 8] = 8'(k);
    base = log_n;
    do_req(1'b1, 64'h1000, line, 2'd3, 8'd7, 0, 1'b0, cyc, rd);
    check("wr8_latency", 512'(cyc), 512'(26));
    check("wr8_beats", 512'(log_n - base), 512'(8));
    check("wr8_rdata", rd, 512'(0));
    for (int i = 0; i < 8; i++) begin
      check($sformatf("wr8_wdata%0d", i), 512'(log_wdata[base+i]), 512'(line[64*i +: 64]));
      check($sformatf("wr8_we%0d", i), 512'(log_we[base+i]), 512'(1));
      check($sformatf("wr8_wstrb%0d", i), 512'(log_wstrb[base+i]), 512'(8'hFF));
    end

    // Single-beat halfword write at offset 6.
    base = log_n;
    do_req(1'b1, 64'h1006, line, 2'd1, 8'd0, 0, 1'b0, cyc, rd);
    check("wr1_latency", 512'(cyc), 512'(5));
    check("wr1_beats", 512'(log_n - base), 512'(1));
    check("wr1_wstrb", 512'(log_wstrb[base]), 512'(8'hC0));
    check("wr1_addr", 512'(log_addr[base]), 512'(64'h1006));
    check("wr1_wdata", 512'(log_wdata[base]), 512'(64'h0706050403020100));

    // Random stalls, valid held 3 cycles past ready.
    base = log_n; rand_mode = 1;
    do_req(1'b0, 64'h2000, '0, 2'd3, 8'd7, 3, 1'b1, cyc, rd);
    check("rnd_beats_no_retrigger", 512'(log_n - base), 512'(8));
    check("rnd_data7", 512'(rd[511:448]), 512'(mem_data(64'h2038)));
    check("rnd_data0", 512'(rd[63:0]), 512'(mem_data(64'h2000)));
    rand_mode = 0;

    // blks = 2 read, zero-wait memory: upper line zero.
    base = log_n; lat_fixed = 0;
    do_req(1'b0, 64'h3000, '0, 2'd3, 8'd2, 0, 1'b0, cyc, rd);
    check("rd3_latency", 512'(cyc), 512'(8));
    check("rd3_beats", 512'(log_n - base), 512'(3));
    check("rd3_upper_zero", 512'(rd[511:192]), 512'(0));
    check("rd3_beat2", 512'(rd[191:128]), 512'(mem_data(64'h3010)));

    // Oversized blks clamps to 8 beats; address wraps past 2^64.
    base = log_n;
    do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFC0, '0, 2'd3, 8'hFF, 0, 1'b0, cyc, rd);
    check("clamp_latency", 512'(cyc), 512'(18));
    check("clamp_beats", 512'(log_n - base), 512'(8));
    check("wrap_last_addr", 512'(log_addr[base+7]), 512'(64'hFFFF_FFFF_FFFF_FFF8));
    base = log_n;
    do_req(1'b0, 64'hFFFF_FFFF_FFFF_FFF8, '0, 2'd3, 8'd1, 0, 1'b0, cyc, rd);
    check("wrap_addr", 512'(log_addr[base+1]), 512'(0));
    check("wrap_data", 512'(rd[127:64]), 512'(mem_data(64'h0)));

    // Reset during beat 4 of an 8-beat read, then a stray ack.
    lat_fixed = 1;
    base = log_n;
    @(negedge clk);
    valid = 1'b1; op = 1'b0; addr = 64'h4000; size = 2'd3; blks = 8'd7;
    cyc = 0;
    while (!((log_n - base) == 4 && mem_req) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_beat4", 512'(cyc < 200), 512'(1));
    #2 rst = 1'b0;
    #1 outputs_zero("async_rst");
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b1; stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_ack_no_req", 512'(mem_req), 512'(0));
    check("stray_ack_no_ready", 512'(ready), 512'(0));
    check("stray_ack_no_beat", 512'(log_n - base), 512'(4));
    base = log_n;
    do_req(1'b0, 64'h4000, '0, 2'd3, 8'd7, 0, 1'b0, cyc, rd);
    check("reissue_latency", 512'(cyc), 512'(26));
    check("reissue_beats", 512'(log_n - base), 512'(8));
    check("reissue_data5", 512'(rd[383:320]), 512'(mem_data(64'h4028)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
